// File: rtl/module_div_8bits.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/ready/done handshake.
// Optional macro DIV_ZERO_FLAG_EN adds the div_by_zero_po status output.
//
// state | meaning
// IDLE  | ready_po=1, waiting for start_pi
// CALC  | shift-and-subtract, one quotient bit per edge
// DONE  | done_po=1 for one cycle, results valid
module module_div_8bits #(
    parameter int WIDTH2 = 8
) (
    input  logic              clk_pi,
    input  logic              rst_n_pi,
    input  logic              start_pi,
    input  logic [WIDTH2-1:0] dividend_pi,
    input  logic [WIDTH2-1:0] divisor_pi,
    output logic              ready_po,
    output logic              done_po,
    output logic [WIDTH2-1:0] quotient_po,
    output logic [WIDTH2-1:0] remainder_po
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic              div_by_zero_po
`endif
);

    localparam int CW = $clog2(WIDTH2 + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nx;
    logic [WIDTH2-1:0] dvd_q;
    logic [WIDTH2-1:0] dvs_q;
    logic [WIDTH2-1:0] rem_q;
    logic [CW-1:0]     cnt_q;

    logic [WIDTH2:0]   shift_rem;
    logic [WIDTH2:0]   trial;
    logic              qbit;
    logic [WIDTH2-1:0] rem_nx;
    logic [WIDTH2-1:0] quo_nx;
    logic              accept;
    logic              last_iter;
    logic              div_zero;

    // dvd_q doubles as the quotient shift register: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    always_comb begin
        shift_rem = {rem_q, dvd_q[WIDTH2-1]};
        trial     = shift_rem - {1'b0, dvs_q};
        qbit      = ~trial[WIDTH2];
        rem_nx    = qbit ? trial[WIDTH2-1:0] : shift_rem[WIDTH2-1:0];
        quo_nx    = {dvd_q[WIDTH2-2:0], qbit};
    end

    always_comb begin
        state_nx  = state;
        ready_po  = 1'b0;
        done_po   = 1'b0;
        accept    = 1'b0;
        div_zero  = (divisor_pi == '0);
        last_iter = (cnt_q == CW'(WIDTH2 - 1));
        case (state)
            IDLE: begin
                ready_po = 1'b1;
                if (start_pi) begin
                    accept   = 1'b1;
                    state_nx = div_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done_po  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            dvd_q        <= '0;
            dvs_q        <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            quotient_po  <= '0;
            remainder_po <= '0;
        end else if (accept) begin
            dvd_q <= dividend_pi;
            dvs_q <= divisor_pi;
            rem_q <= '0;
            cnt_q <= '0;
            // Zero divisor skips CALC; results are loaded on the way straight to DONE.
            if (div_zero) begin
                quotient_po  <= '1;
                remainder_po <= dividend_pi;
            end
        end else if (state == CALC) begin
            dvd_q <= quo_nx;
            rem_q <= rem_nx;
            cnt_q <= cnt_q + 1'b1;
            if (last_iter) begin
                quotient_po  <= quo_nx;
                remainder_po <= rem_nx;
            end
        end
    end

`ifdef DIV_ZERO_FLAG_EN
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            div_by_zero_po <= 1'b0;
        end else if (accept) begin
            div_by_zero_po <= div_zero;
        end
    end
`endif

endmodule

// File: tb/tb_module_div_8bits.sv
// Self-checking bench for module_div_8bits: vector table, handshake corner cases,
// and a random run with start held high; results checked through a scoreboard queue.
module tb_module_div_8bits;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       ready;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
`ifdef DIV_ZERO_FLAG_EN
    logic       dz;
`endif

    module_div_8bits #(.WIDTH2(8)) dut (
        .clk_pi       (clk),
        .rst_n_pi     (rst_n),
        .start_pi     (start),
        .dividend_pi  (dividend),
        .divisor_pi   (divisor),
        .ready_po     (ready),
        .done_po      (done),
        .quotient_po  (quotient),
        .remainder_po (remainder)
`ifdef DIV_ZERO_FLAG_EN
        ,
        .div_by_zero_po (dz)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        bit         z;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        bit         z;
        int         lat;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    logic [7:0] prev_q = '0;
    logic [7:0] prev_r = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        e.z = (b == 0);
        e.q = (b == 0) ? 8'hFF : a / b;
        e.r = (b == 0) ? a : a % b;
        return e;
    endfunction

    // Scoreboard: every done_po pops one expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            check("ready_low_during_done", ready, 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=%0d/%0d required=none", quotient, remainder);
            end else begin
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                if (e.b != 0) begin
                    check("invariant", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
                    check("rem_lt_div", (remainder < e.b), 1);
                end
`ifdef DIV_ZERO_FLAG_EN
                check("div_by_zero_flag", dz, e.z);
`endif
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", ready, 1);
    endtask

    // Issue one division from a negedge and follow it until ready returns.
    task automatic run_op(input exp_t e, input int exp_lat, input string tag);
        int cycles = 0;
        int lat = -1;
        wait_ready();
        dividend = e.a;
        divisor  = e.b;
        start    = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
`ifdef DIV_ZERO_FLAG_EN
        check({tag, "_flag_at_accept"}, dz, e.z);
`endif
        while (!ready && cycles < 50) begin
            if (done) lat = cycles;
            cycles++;
            @(negedge clk);
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_ready_low_cycles"}, cycles, exp_lat + 1);
        prev_q = e.q;
        prev_r = e.r;
    endtask

    vec_t vecs[10];

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int cycles;
        int lat;
        int pushed;
        int cyc;
        int done_base;
        exp_t e;

        vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,  1'b0, 8};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 8};
        vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 8};
        vecs[3] = '{8'd0,   8'd3,   8'd0,   8'd0,  1'b0, 8};
        vecs[4] = '{8'd128, 8'd128, 8'd1,   8'd0,  1'b0, 8};
        vecs[5] = '{8'd250, 8'd16,  8'd15,  8'd10, 1'b0, 8};
        vecs[6] = '{8'd1,   8'd255, 8'd0,   8'd1,  1'b0, 8};
        vecs[7] = '{8'd255, 8'd200, 8'd1,   8'd55, 1'b0, 8};
        vecs[8] = '{8'd77,  8'd0,   8'd255, 8'd77, 1'b1, 0};
        vecs[9] = '{8'd10,  8'd2,   8'd5,   8'd0,  1'b0, 8};

        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
`ifdef DIV_ZERO_FLAG_EN
        check("rst_flag", dz, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            e.a = vecs[i].a;
            e.b = vecs[i].b;
            e.q = vecs[i].q;
            e.r = vecs[i].r;
            e.z = vecs[i].z;
            run_op(e, vecs[i].lat, $sformatf("vec%0d", i));
        end

        // start pulse during CALC must be ignored; outputs hold until done.
        wait_ready();
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        sb.push_back(model(8'd200, 8'd7));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        lat = -1;
        while (!ready && cycles < 50) begin
            if (cycles == 2) begin
                start    = 1'b1;
                dividend = 8'd100;
                divisor  = 8'd3;
            end else begin
                start = 1'b0;
            end
            if (done) lat = cycles;
            else begin
                check("hold_quotient", quotient, prev_q);
                check("hold_remainder", remainder, prev_r);
            end
            cycles++;
            @(negedge clk);
        end
        start = 1'b0;
        check("ignore_latency", lat, 8);
        repeat (12) @(negedge clk);
        check("ignore_sb_empty", sb.size(), 0);
        prev_q = 8'd28;
        prev_r = 8'd4;

        // Asynchronous reset in the middle of CALC.
        wait_ready();
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        sb.push_back(model(8'd200, 8'd7));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_ready", ready, 1);
        check("midrst_done", done, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(model(8'd9, 8'd2), 8, "post_rst");
        check("post_rst_q_value", prev_q, 8'd4);

        // Random run, start held high.
        done_base = done_cnt;
        pushed = 0;
        cyc = 0;
        while (pushed < 1000 && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (ready) begin
                logic [7:0] a;
                logic [7:0] b;
                a = 8'($urandom);
                b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
                dividend = a;
                divisor  = b;
                start    = 1'b1;
                sb.push_back(model(a, b));
                pushed++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (sb.size() != 0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        repeat (12) @(negedge clk);
        check("random_pushed", pushed, 1000);
        check("random_sb_empty", sb.size(), 0);
        check("random_done_count", done_cnt - done_base, 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
